// File: rtl/nway_wb_data_cache.sv
// N-way set-associative, write-back, write-allocate data cache with one 32-bit word per line.
// Define CACHE_STATS_EN to add saturating HitCount/MissCount/WriteBackCount outputs.
module nway_wb_data_cache #(
    parameter int unsigned WAYS = 4,
    parameter int unsigned SETS = 256
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic        WriteEnable,
    input  logic [3:0]  ByteEn,
    input  logic [31:0] RWAddr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        ReadReady,
    output logic        WriteReady,
    output logic        MemReadStart,
    output logic [31:0] MemReadAddr,
    input  logic [31:0] MemReadData,
    input  logic        MemReadFinish,
    output logic        MemWriteStart,
    output logic [31:0] MemWriteAddr,
    output logic [31:0] MemWriteData,
    input  logic        MemWriteFinish
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] HitCount,
    output logic [31:0] MissCount,
    output logic [31:0] WriteBackCount
`endif
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 30 - IDX_W;
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {StIdle, StRespond, StWriteBack, StReadMem, StAllocate} state_e;
    state_e state_q, state_d;

    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];
    logic [WAY_W-1:0] ptr_q   [SETS];
    logic [TAG_W-1:0] tag_q   [WAYS][SETS];
    logic [31:0]      data_q  [WAYS][SETS];

    logic             req_we_q;
    logic [3:0]       req_be_q;
    logic [29:0]      req_addr_q;
    logic [31:0]      req_wdata_q;
    logic [WAY_W-1:0] way_q;
    logic [31:0]      fill_q;

    logic [29:0]      lk_addr;
    logic [IDX_W-1:0] lk_idx, idx_q;
    logic [TAG_W-1:0] lk_tag, req_tag;
    logic             hit, victim_dirty, accept;
    logic [WAY_W-1:0] hit_way, victim_way, ptr_inc;
    logic [31:0]      line_data, merged;
    logic [1:0]       unused_addr_lsb;

    assign unused_addr_lsb = RWAddr[1:0];

    // In IDLE the lookup must see the incoming address so a hit can respond next cycle.
    assign lk_addr = (state_q == StIdle) ? RWAddr[31:2] : req_addr_q;
    assign lk_idx  = lk_addr[IDX_W-1:0];
    assign lk_tag  = lk_addr[29:IDX_W];
    assign idx_q   = req_addr_q[IDX_W-1:0];
    assign req_tag = req_addr_q[29:IDX_W];
    assign accept  = (state_q == StIdle) && Start;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (valid_q[lk_idx][w] && (tag_q[w][lk_idx] == lk_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        victim_way = ptr_q[lk_idx];
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!valid_q[lk_idx][w]) victim_way = WAY_W'(w);
        end
    end

    assign victim_dirty = valid_q[lk_idx][victim_way] & dirty_q[lk_idx][victim_way];
    assign ptr_inc      = (ptr_q[idx_q] == WAY_W'(WAYS - 1)) ? '0 : ptr_q[idx_q] + 1'b1;
    assign line_data    = data_q[way_q][idx_q];

    always_comb begin
        merged = line_data;
        for (int b = 0; b < 4; b++) begin
            if (req_be_q[b]) merged[8*b +: 8] = req_wdata_q[8*b +: 8];
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    if (hit)               state_d = StRespond;
                    else if (victim_dirty) state_d = StWriteBack;
                    else                   state_d = StReadMem;
                end
            end
            StWriteBack: if (MemWriteFinish) state_d = StReadMem;
            StReadMem:   if (MemReadFinish)  state_d = StAllocate;
            StAllocate:  state_d = StRespond;
            StRespond:   state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_comb begin
        ReadData      = '0;
        ReadReady     = 1'b0;
        WriteReady    = 1'b0;
        MemReadStart  = 1'b0;
        MemReadAddr   = '0;
        MemWriteStart = 1'b0;
        MemWriteAddr  = '0;
        MemWriteData  = '0;
        unique case (state_q)
            StRespond: begin
                ReadReady  = !req_we_q;
                WriteReady = req_we_q;
                if (!req_we_q) ReadData = line_data;
            end
            StWriteBack: begin
                MemWriteStart = 1'b1;
                MemWriteAddr  = {tag_q[way_q][idx_q], idx_q, 2'b00};
                MemWriteData  = line_data;
            end
            StReadMem: begin
                MemReadStart = 1'b1;
                MemReadAddr  = {req_addr_q, 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            for (int s = 0; s < int'(SETS); s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
            req_we_q    <= 1'b0;
            req_be_q    <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            way_q       <= '0;
            fill_q      <= '0;
        end else begin
            if (accept) begin
                req_we_q    <= WriteEnable;
                req_be_q    <= ByteEn;
                req_addr_q  <= RWAddr[31:2];
                req_wdata_q <= WriteData;
                way_q       <= hit ? hit_way : victim_way;
            end
            if ((state_q == StWriteBack) && MemWriteFinish) dirty_q[idx_q][way_q] <= 1'b0;
            if ((state_q == StReadMem) && MemReadFinish) fill_q <= MemReadData;
            if (state_q == StAllocate) begin
                valid_q[idx_q][way_q] <= 1'b1;
                dirty_q[idx_q][way_q] <= 1'b0;
                // Only evicting a live line advances the pointer; filling a hole does not.
                if (valid_q[idx_q][way_q]) ptr_q[idx_q] <= ptr_inc;
            end
            if ((state_q == StRespond) && req_we_q) dirty_q[idx_q][way_q] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset_n && (state_q == StAllocate)) begin
            data_q[way_q][idx_q] <= fill_q;
            tag_q[way_q][idx_q]  <= req_tag;
        end else if (Reset_n && (state_q == StRespond) && req_we_q) begin
            data_q[way_q][idx_q] <= merged;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else if (accept) begin
            if (hit && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (!hit && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
            if (!hit && victim_dirty && (wb_cnt_q != '1)) wb_cnt_q <= wb_cnt_q + 32'd1;
        end
    end

    assign HitCount       = hit_cnt_q;
    assign MissCount      = miss_cnt_q;
    assign WriteBackCount = wb_cnt_q;
`endif

endmodule

// File: tb/tb_nway_wb_data_cache.sv
// Randomised self-checking bench for nway_wb_data_cache against a set/way reference model.
// Connects the statistics outputs when CACHE_STATS_EN is defined.
module tb_nway_wb_data_cache;

    localparam int WAYS = 4;
    localparam int SETS = 256;

    logic        CLK = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0, WriteEnable = 1'b0;
    logic [3:0]  ByteEn = '0;
    logic [31:0] RWAddr = '0, WriteData = '0;
    logic [31:0] ReadData, MemReadAddr, MemWriteAddr, MemWriteData;
    logic        ReadReady, WriteReady, MemReadStart, MemWriteStart;
    logic [31:0] MemReadData = '0;
    logic        MemReadFinish = 1'b0, MemWriteFinish = 1'b0;
`ifdef CACHE_STATS_EN
    logic [31:0] HitCount, MissCount, WriteBackCount;
`endif

    nway_wb_data_cache #(.WAYS(WAYS), .SETS(SETS)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .WriteEnable(WriteEnable),
        .ByteEn(ByteEn), .RWAddr(RWAddr), .WriteData(WriteData), .ReadData(ReadData),
        .ReadReady(ReadReady), .WriteReady(WriteReady), .MemReadStart(MemReadStart),
        .MemReadAddr(MemReadAddr), .MemReadData(MemReadData), .MemReadFinish(MemReadFinish),
        .MemWriteStart(MemWriteStart), .MemWriteAddr(MemWriteAddr),
        .MemWriteData(MemWriteData), .MemWriteFinish(MemWriteFinish)
`ifdef CACHE_STATS_EN
        , .HitCount(HitCount), .MissCount(MissCount), .WriteBackCount(WriteBackCount)
`endif
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit rr; bit wr; logic [31:0] rdata; int lat;
        bit rd; logic [31:0] rd_addr; int rd_first; int rfin;
        bit wb; logic [31:0] wb_addr; logic [31:0] wb_data; int wfin;
        bit clash; bit timeout;
    } res_t;

    typedef struct {
        bit hit; bit wb; logic [31:0] wb_addr; logic [31:0] wb_data; logic [31:0] rdata;
    } exp_t;

    // Reference model: per-set way contents, replacement pointer, backing memory by word.
    bit          m_valid [SETS][WAYS];
    bit          m_dirty [SETS][WAYS];
    logic [21:0] m_tag   [SETS][WAYS];
    logic [31:0] m_data  [SETS][WAYS];
    int          m_ptr   [SETS];
    logic [31:0] mem [int unsigned];
    int          m_hits, m_misses, m_wbs;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
            end
        end
        m_hits = 0; m_misses = 0; m_wbs = 0;
    endtask

    task automatic model_access(input bit we, input logic [3:0] be, input logic [31:0] addr,
                                input logic [31:0] wd, output exp_t e);
        logic [7:0]  s;
        logic [21:0] t;
        int          way;
        int unsigned key;
        s = addr[9:2];
        t = addr[31:10];
        key = {2'b00, addr[31:2]};
        way = -1;
        e = '{default: 0};
        for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == t) way = w;
        e.hit = (way >= 0);
        if (e.hit) begin
            m_hits++;
        end else begin
            m_misses++;
            for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) way = w;
            if (way < 0) begin
                way = m_ptr[s];
                m_ptr[s] = (m_ptr[s] + 1) % WAYS;
            end
            if (m_valid[s][way] && m_dirty[s][way]) begin
                e.wb = 1;
                e.wb_addr = {m_tag[s][way], s, 2'b00};
                e.wb_data = m_data[s][way];
                mem[{2'b00, m_tag[s][way], s}] = m_data[s][way];
                m_wbs++;
            end
            if (!mem.exists(key)) mem[key] = $urandom;
            m_valid[s][way] = 1;
            m_dirty[s][way] = 0;
            m_tag[s][way] = t;
            m_data[s][way] = mem[key];
        end
        if (we) begin
            for (int b = 0; b < 4; b++) if (be[b]) m_data[s][way][8*b +: 8] = wd[8*b +: 8];
            m_dirty[s][way] = 1;
        end else begin
            e.rdata = m_data[s][way];
        end
    endtask

    // Issues one request and plays the memory side; with noisy set, CPU inputs and idle
    // Finish lines are scrambled while the cache is busy.
    task automatic run_req(input bit we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wd, input bit noisy, output res_t r);
        int wcnt, rcnt, wdly, rdly;
        r = '{default: 0};
        r.rd_first = -1; r.rfin = -1; r.wfin = -1;
        wcnt = 0; rcnt = 0;
        wdly = $urandom_range(0, 3);
        rdly = $urandom_range(0, 3);
        @(negedge CLK);
        Start = 1; WriteEnable = we; ByteEn = be; RWAddr = addr; WriteData = wd;
        MemReadFinish = 0; MemWriteFinish = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge CLK);
            if (ReadReady || WriteReady) begin
                r.rr = ReadReady; r.wr = WriteReady; r.rdata = ReadData; r.lat = c;
                r.clash = MemReadStart || MemWriteStart;
                Start = 0; MemReadFinish = 0; MemWriteFinish = 0;
                return;
            end
            Start = noisy;
            if (noisy) begin
                WriteEnable = 1'($urandom); ByteEn = 4'($urandom);
                RWAddr = $urandom; WriteData = $urandom;
            end
            if (MemWriteStart) begin
                if (!r.wb) begin
                    r.wb = 1; r.wb_addr = MemWriteAddr; r.wb_data = MemWriteData;
                end
                MemWriteFinish = (wcnt >= wdly);
                if (MemWriteFinish) r.wfin = c;
                wcnt++;
            end else begin
                MemWriteFinish = noisy ? 1'($urandom) : 1'b0;
            end
            if (MemReadStart) begin
                if (!r.rd) begin
                    r.rd = 1; r.rd_addr = MemReadAddr; r.rd_first = c;
                end
                MemReadFinish = (rcnt >= rdly);
                MemReadData = $urandom;
                if (MemReadFinish) begin
                    r.rfin = c;
                    if (mem.exists({2'b00, MemReadAddr[31:2]})) MemReadData = mem[{2'b00, MemReadAddr[31:2]}];
                end
                rcnt++;
            end else begin
                MemReadFinish = noisy ? 1'($urandom) : 1'b0;
                MemReadData = $urandom;
            end
        end
        r.timeout = 1;
        Start = 0; MemReadFinish = 0; MemWriteFinish = 0;
    endtask

    task automatic test_reset();
        Reset_n = 0;
        Start = 1; WriteEnable = 1; RWAddr = 32'h100;
        repeat (2) @(negedge CLK);
        n_vec++;
        if ({ReadReady, WriteReady, MemReadStart, MemWriteStart} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_strobes: got %b, want 0000",
                     {ReadReady, WriteReady, MemReadStart, MemWriteStart});
        end
        n_vec++;
        if ({ReadData, MemReadAddr, MemWriteAddr, MemWriteData} !== 128'b0) begin
            n_err++;
            $display("FAIL reset_buses: rd=%h mra=%h mwa=%h mwd=%h, want all 0",
                     ReadData, MemReadAddr, MemWriteAddr, MemWriteData);
        end
        Start = 0; WriteEnable = 0; RWAddr = 0;
        Reset_n = 1;
        model_reset();
    endtask

    task automatic test_directed();
        exp_t e;
        res_t r;
        logic [31:0] conflict [3];
        conflict[0] = 32'h500; conflict[1] = 32'h900; conflict[2] = 32'hD00;
        mem[32'h40] = 32'hDEAD_BEEF;
        mem[32'h800] = 32'h0;

        model_access(0, 4'h0, 32'h100, 32'h0, e);
        run_req(0, 4'h0, 32'h100, 32'h0, 0, r);
        n_vec++;
        if (!(r.rd && r.rd_addr === 32'h100)) begin
            n_err++; $display("FAIL cold_load_memread: rd=%0b addr=%h, want 1 00000100", r.rd, r.rd_addr);
        end
        n_vec++;
        if (!(r.rr && r.rdata === 32'hDEAD_BEEF && r.lat == r.rfin + 2)) begin
            n_err++;
            $display("FAIL cold_load_data: rr=%0b data=%h lat=%0d, want 1 deadbeef lat %0d",
                     r.rr, r.rdata, r.lat, r.rfin + 2);
        end

        model_access(0, 4'h0, 32'h100, 32'h0, e);
        run_req(0, 4'h0, 32'h100, 32'h0, 0, r);
        n_vec++;
        if (!(r.rr && r.lat == 1 && !r.rd && r.rdata === 32'hDEAD_BEEF)) begin
            n_err++;
            $display("FAIL hit_load: rr=%0b lat=%0d rd=%0b data=%h, want 1 1 0 deadbeef",
                     r.rr, r.lat, r.rd, r.rdata);
        end
`ifdef CACHE_STATS_EN
        n_vec++;
        if (HitCount !== 32'd1 || MissCount !== 32'd1) begin
            n_err++; $display("FAIL stats_after_hit: hit=%0d miss=%0d, want 1 1", HitCount, MissCount);
        end
`endif

        model_access(1, 4'b0011, 32'h100, 32'h1122_3344, e);
        run_req(1, 4'b0011, 32'h100, 32'h1122_3344, 0, r);
        n_vec++;
        if (!(r.wr && !r.rr && r.lat == 1 && !r.rd && !r.wb)) begin
            n_err++;
            $display("FAIL hit_store: wr=%0b lat=%0d rd=%0b wb=%0b, want 1 1 0 0", r.wr, r.lat, r.rd, r.wb);
        end
        model_access(0, 4'h0, 32'h100, 32'h0, e);
        run_req(0, 4'h0, 32'h100, 32'h0, 0, r);
        n_vec++;
        if (r.rdata !== 32'hDEAD_3344) begin
            n_err++; $display("FAIL byte_merge: got %h, want dead3344", r.rdata);
        end

        foreach (conflict[i]) begin
            model_access(0, 4'h0, conflict[i], 32'h0, e);
            run_req(0, 4'h0, conflict[i], 32'h0, 0, r);
            n_vec++;
            if (!(r.rd && !r.wb && r.rdata === e.rdata)) begin
                n_err++;
                $display("FAIL fill_way_%0d: rd=%0b wb=%0b data=%h, want 1 0 %h",
                         i + 1, r.rd, r.wb, r.rdata, e.rdata);
            end
        end
        model_access(0, 4'h0, 32'h1100, 32'h0, e);
        run_req(0, 4'h0, 32'h1100, 32'h0, 0, r);
        n_vec++;
        if (!(r.wb && r.wb_addr === 32'h100 && r.wb_data === 32'hDEAD_3344)) begin
            n_err++;
            $display("FAIL dirty_evict: wb=%0b addr=%h data=%h, want 1 00000100 dead3344",
                     r.wb, r.wb_addr, r.wb_data);
        end
        n_vec++;
        if (!(r.rd && r.rd_addr === 32'h1100 && r.rd_first > r.wfin && r.rr)) begin
            n_err++;
            $display("FAIL evict_refill: rd=%0b addr=%h rd_first=%0d wfin=%0d, want refill 1100 after wb",
                     r.rd, r.rd_addr, r.rd_first, r.wfin);
        end

        model_access(1, 4'b1000, 32'h2000, 32'hAA55_1234, e);
        run_req(1, 4'b1000, 32'h2000, 32'hAA55_1234, 0, r);
        n_vec++;
        if (!(r.wr && r.rd && r.rd_addr === 32'h2000)) begin
            n_err++; $display("FAIL store_miss: wr=%0b rd=%0b addr=%h, want 1 1 00002000", r.wr, r.rd, r.rd_addr);
        end
        model_access(0, 4'h0, 32'h2000, 32'h0, e);
        run_req(0, 4'h0, 32'h2000, 32'h0, 0, r);
        n_vec++;
        if (r.rdata !== 32'hAA00_0000) begin
            n_err++; $display("FAIL store_allocate_merge: got %h, want aa000000", r.rdata);
        end

        model_access(1, 4'b0000, 32'h2000, 32'hFFFF_FFFF, e);
        run_req(1, 4'b0000, 32'h2000, 32'hFFFF_FFFF, 0, r);
        model_access(0, 4'h0, 32'h2000, 32'h0, e);
        run_req(0, 4'h0, 32'h2000, 32'h0, 0, r);
        n_vec++;
        if (r.rdata !== 32'hAA00_0000) begin
            n_err++; $display("FAIL empty_byteen_store: got %h, want aa000000", r.rdata);
        end
    endtask

    task automatic test_reset_mid_op();
        exp_t e;
        res_t r;
        @(negedge CLK);
        Start = 1; WriteEnable = 0; RWAddr = 32'h4000;
        @(negedge CLK);
        Start = 0;
        n_vec++;
        if (MemReadStart !== 1'b1) begin
            n_err++; $display("FAIL midop_memread_up: got %b, want 1", MemReadStart);
        end
        Reset_n = 0;
        @(negedge CLK);
        n_vec++;
        if ({MemReadStart, ReadReady} !== 2'b00) begin
            n_err++; $display("FAIL midop_reset_drop: got %b, want 00", {MemReadStart, ReadReady});
        end
        Reset_n = 1;
        model_reset();
        model_access(0, 4'h0, 32'h4000, 32'h0, e);
        run_req(0, 4'h0, 32'h4000, 32'h0, 0, r);
        n_vec++;
        if (!(r.rd && r.rd_addr === 32'h4000 && r.rdata === e.rdata)) begin
            n_err++;
            $display("FAIL midop_reload: rd=%0b addr=%h data=%h, want 1 00004000 %h",
                     r.rd, r.rd_addr, r.rdata, e.rdata);
        end
        model_access(0, 4'h0, 32'h500, 32'h0, e);
        run_req(0, 4'h0, 32'h500, 32'h0, 0, r);
        n_vec++;
        if (!(r.rd && !r.wb)) begin
            n_err++; $display("FAIL reset_clears_valid: rd=%0b wb=%0b, want 1 0", r.rd, r.wb);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        res_t r;
        logic [31:0] a, d;
        logic [3:0]  be;
        for (int i = 0; i < 12; i++) begin
            a = (32'($urandom_range(0, 5)) << 10) | (32'h41 << 2);
            d = $urandom;
            be = 4'($urandom);
            model_access(1, be, a, d, e);
            run_req(1, be, a, d, 1, r);
            model_access(0, 4'h0, a, 32'h0, e);
            run_req(0, 4'h0, a, 32'h0, 1, r);
            n_vec++;
            if (!(r.rr && !r.timeout && r.rdata === e.rdata)) begin
                n_err++;
                $display("FAIL b2b_%0d: rr=%0b data=%h, want 1 %h", i, r.rr, r.rdata, e.rdata);
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        res_t r;
        bit          we, noisy;
        logic [3:0]  be;
        logic [31:0] a, d;
        for (int i = 0; i < 250; i++) begin
            we = 1'($urandom);
            be = 4'($urandom);
            noisy = 1'($urandom);
            a = (32'($urandom_range(0, 7)) << 10) | (32'($urandom_range(32'h40, 32'h41)) << 2)
                | 32'($urandom_range(0, 3));
            d = $urandom;
            model_access(we, be, a, d, e);
            run_req(we, be, a, d, noisy, r);
            n_vec++;
            if (r.timeout || r.clash || (we ? !(r.wr && !r.rr) : !(r.rr && !r.wr))) begin
                n_err++;
                $display("FAIL rnd_%0d_handshake: to=%0b clash=%0b rr=%0b wr=%0b we=%0b",
                         i, r.timeout, r.clash, r.rr, r.wr, we);
            end
            n_vec++;
            if (r.rd !== !e.hit || r.wb !== e.wb) begin
                n_err++;
                $display("FAIL rnd_%0d_traffic: rd=%0b wb=%0b, want rd=%0b wb=%0b",
                         i, r.rd, r.wb, !e.hit, e.wb);
            end
            if (e.hit) begin
                n_vec++;
                if (r.lat != 1) begin
                    n_err++; $display("FAIL rnd_%0d_hit_latency: got %0d, want 1", i, r.lat);
                end
            end else begin
                n_vec++;
                if (r.rd_addr !== {a[31:2], 2'b00} || r.lat != r.rfin + 2) begin
                    n_err++;
                    $display("FAIL rnd_%0d_miss: addr=%h lat=%0d, want %h lat %0d",
                             i, r.rd_addr, r.lat, {a[31:2], 2'b00}, r.rfin + 2);
                end
            end
            if (e.wb) begin
                n_vec++;
                if (r.wb_addr !== e.wb_addr || r.wb_data !== e.wb_data || r.rd_first <= r.wfin) begin
                    n_err++;
                    $display("FAIL rnd_%0d_writeback: addr=%h data=%h, want %h %h",
                             i, r.wb_addr, r.wb_data, e.wb_addr, e.wb_data);
                end
            end
            if (!we) begin
                n_vec++;
                if (r.rdata !== e.rdata) begin
                    n_err++; $display("FAIL rnd_%0d_load_data: got %h, want %h", i, r.rdata, e.rdata);
                end
            end
        end
`ifdef CACHE_STATS_EN
        n_vec++;
        if (HitCount !== 32'(m_hits) || MissCount !== 32'(m_misses) || WriteBackCount !== 32'(m_wbs)) begin
            n_err++;
            $display("FAIL stats_random: hit=%0d miss=%0d wb=%0d, want %0d %0d %0d",
                     HitCount, MissCount, WriteBackCount, m_hits, m_misses, m_wbs);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
